// File: rtl/gray_sync_rx.sv
// rtl/gray_sync_rx.sv - Gray pointer receiver: synchronizer, binary decode, increment accumulator
// Sticky err flags multi-bit Gray transitions; ovf flags accumulator saturation.
module gray_sync_rx #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] delta,
   output logic             delta_valid,
   input  logic             delta_ready,
   output logic             err,
   output logic             ovf
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] g_cur;
   logic [WIDTH-1:0] g_prev;
   logic [WIDTH-1:0] b_cur;
   logic [WIDTH-1:0] inc;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   sum;
   logic             xfer;
   logic             multi_bit;
   logic             sat;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Plain flop chain: nothing may sit between stages or metastability settles poorly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign g_cur       = sync_q[SYNC_STAGES-1];
   assign delta_valid = (delta != '0);

   always_comb begin
      b_cur     = gray2bin(g_cur);
      inc       = b_cur - bin_out;
      xfer      = delta_valid & delta_ready;
      base      = xfer ? '0 : delta;
      sum       = {1'b0, base} + {1'b0, inc};
      sat       = sum[WIDTH];
      diff      = g_cur ^ g_prev;
      // Clearing the lowest set bit leaves something only if two or more bits changed.
      multi_bit = |(diff & (diff - WIDTH'(1)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         g_prev  <= '0;
         bin_out <= '0;
         delta   <= '0;
         err     <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         g_prev  <= g_cur;
         bin_out <= b_cur;
         delta   <= sat ? '1 : sum[WIDTH-1:0];
         err     <= multi_bit | (err & ~clr_err);
         ovf     <= sat | (ovf & ~clr_err);
      end
   end

endmodule

// File: tb/tb_gray_sync_rx.sv
// tb/tb_gray_sync_rx.sv - directed self-checking bench for gray_sync_rx (WIDTH=4, SYNC_STAGES=2)
module tb_gray_sync_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] gray_in;
   logic       clr_err;
   logic [3:0] bin_out;
   logic [3:0] delta;
   logic       delta_valid;
   logic       delta_ready;
   logic       err;
   logic       ovf;

   int n_checks = 0;
   int n_pass   = 0;

   gray_sync_rx #(.WIDTH(4), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .gray_in     (gray_in),
      .clr_err     (clr_err),
      .bin_out     (bin_out),
      .delta       (delta),
      .delta_valid (delta_valid),
      .delta_ready (delta_ready),
      .err         (err),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [3:0] bin2gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One source step per destination cycle keeps every synchronized change single-bit.
   task automatic step_to(input int v);
      logic [3:0] b;
      b = v[3:0];
      gray_in = bin2gray(b);
      tick(1);
   endtask

   task automatic async_reset();
      #3;
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      gray_in     = 4'b0110;
      clr_err     = 1'b0;
      delta_ready = 1'b0;

      for (int r = 0; r < 3; r++) begin
         tick(1);
         check("rst_bin", bin_out, 0);
         check("rst_delta", delta, 0);
         check("rst_valid", delta_valid, 0);
         check("rst_err", err, 0);
         check("rst_ovf", ovf, 0);
      end
      gray_in = 4'b0000;
      reset   = 1'b0;
      tick(4);
      check("idle_delta", delta, 0);

      // single step
      delta_ready = 1'b1;
      gray_in     = 4'b0001;
      tick(2);
      check("step_early_valid", delta_valid, 0);
      tick(1);
      check("step_bin", bin_out, 1);
      check("step_delta", delta, 1);
      check("step_valid", delta_valid, 1);
      tick(1);
      check("step_valid_drop", delta_valid, 0);
      check("step_delta_drop", delta, 0);

      // walk to 12, drain, then wrap 13,14,15,0,1 under backpressure
      for (int v = 2; v <= 12; v++) step_to(v);
      tick(4);
      check("walk_bin", bin_out, 12);
      check("walk_delta", delta, 0);
      delta_ready = 1'b0;
      step_to(13);
      step_to(14);
      step_to(15);
      step_to(0);
      step_to(1);
      tick(3);
      check("wrap_delta", delta, 5);
      check("wrap_bin", bin_out, 1);
      check("wrap_valid", delta_valid, 1);
      check("wrap_err", err, 0);
      delta_ready = 1'b1;
      tick(1);
      check("wrap_xfer_delta", delta, 0);
      check("wrap_xfer_valid", delta_valid, 0);

      // transfer coinciding with inc=1
      delta_ready = 1'b0;
      step_to(2);
      step_to(3);
      step_to(4);
      tick(3);
      check("xi_pre_delta", delta, 3);
      gray_in = bin2gray(4'd5);
      tick(2);
      check("xi_hold_delta", delta, 3);
      delta_ready = 1'b1;
      tick(1);
      check("xi_delta", delta, 1);
      check("xi_valid", delta_valid, 1);
      check("xi_bin", bin_out, 5);
      tick(1);
      check("xi_drain", delta, 0);

      // mid-operation asynchronous reset
      async_reset();
      check("async_bin", bin_out, 0);
      check("async_delta", delta, 0);
      gray_in = 4'b0000;
      tick(1);
      reset = 1'b0;
      tick(2);

      // coding error 0000 -> 0011
      gray_in = 4'b0011;
      tick(2);
      check("cerr_early", err, 0);
      tick(1);
      check("cerr_set", err, 1);
      check("cerr_bin", bin_out, 2);
      tick(3);
      check("cerr_sticky", err, 1);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      check("cerr_clear", err, 0);
      gray_in = 4'b0000;
      tick(2);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      check("cerr_set_wins", err, 1);
      tick(4);
      check("cerr_bin_back", bin_out, 0);
      check("cerr_drained", delta, 0);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      check("cerr_clear2", err, 0);

      // saturation: 20 steps with no consumer
      delta_ready = 1'b0;
      for (int v = 1; v <= 20; v++) step_to(v % 16);
      tick(3);
      check("sat_delta", delta, 15);
      check("sat_ovf", ovf, 1);
      check("sat_bin", bin_out, 4);
      check("sat_valid", delta_valid, 1);
      check("sat_err", err, 0);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      check("sat_ovf_clear", ovf, 0);
      check("sat_delta_hold", delta, 15);
      delta_ready = 1'b1;
      tick(1);
      check("sat_xfer", delta, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gray_sync_rx.md
# gray_sync_rx

Receive side of a Gray-coded pointer crossing. It takes the free-running Gray count produced by `gray_ctr` in a foreign clock domain and resynchronizes it into `clk`. It converts the count back to binary and turns successive samples into an increment count, delivered over a valid/ready handshake. It also flags Gray-coding violations and accumulator overflow as sticky errors.

## Interface
- `WIDTH`, default 4: counter width, must match the upstream `gray_ctr`; 2 or more.
- `SYNC_STAGES`, default 2: synchronizer flop depth; 2 or more.
- `clk` in 1: destination clock.
- `reset` in 1: asynchronous, active-high; clears all state. This block is reset by the same reset as the upstream counter.
- `gray_in` in `WIDTH`: Gray count from the source domain; asynchronous to `clk`.
- `clr_err` in 1: synchronous clear of `err` and `ovf`.
- `bin_out` out `WIDTH`: latest synchronized count, binary.
- `delta` out `WIDTH`: increments accumulated since the last transfer.
- `delta_valid` out 1: `delta` is non-zero.
- `delta_ready` in 1: consumer accepts `delta` this cycle.
- `err` out 1: sticky; set when a synchronized sample differs from the previous one in more than one bit.
- `ovf` out 1: sticky; set when the accumulator saturates.

## Operation
- **Synchronizer**
  - The chain `s[0..SYNC_STAGES-1]` shifts `gray_in` in on every edge.
  - `g_cur = s[SYNC_STAGES-1]`.
  - No logic between stages.
- **Gray to binary**
  - `b[WIDTH-1] = g[WIDTH-1]`.
  - `b[i] = b[i+1] ^ g[i]` for i = WIDTH-2 down to 0.
  - `b_cur = gray2bin(g_cur)`.
- **Sample registers**
  - `g_prev <= g_cur` on every edge.
  - `bin_out <= b_cur` on every edge.
- **Increment**
  - `inc = (b_cur - bin_out) mod 2^WIDTH`.
  - Unsigned, wraps naturally, so 15 -> 0 with `WIDTH`=4 gives `inc`=1.
- **Accumulator (`delta` register, `WIDTH` bits)**
  - `xfer = delta_valid & delta_ready`.
  - `base = xfer ? 0 : delta`.
  - `sum = base + inc`, computed at `WIDTH+1` bits.
  - If `sum > 2^WIDTH-1`: `delta <= 2^WIDTH-1` and `ovf <= 1`.
  - Otherwise `delta <= sum`.
- **Valid**
  - `delta_valid` is combinational: `delta != 0`.
  - `delta` is a live count. While `delta_valid && !delta_ready` it may grow, but it never decreases.
  - The consumer takes the value present at the transfer edge. No increment is lost or double-counted, except above saturation.
- **Coding check**
  - If `popcount(g_cur ^ g_prev) > 1`, then `err <= 1` on that edge.
  - This fires on a non-Gray source, or when the source advances more than one step per destination cycle.
  - `inc` and `bin_out` still update normally.
- **Error clear**
  - `clr_err` clears `err` and `ovf` on the next edge.
  - If a set condition occurs on the same edge as `clr_err`, the set wins.

## Timing
- **Reset:** all synchronizer stages, `g_prev`, `bin_out`, `delta`, `err` and `ovf` are 0. `delta_valid` is 0.
- **Input to `g_cur`:** a change on `gray_in` captured at edge t appears on `g_cur` after edge t+SYNC_STAGES-1.
- **Input to outputs:** `bin_out`, `delta`, `err` and `ovf` reflect that change after edge t+SYNC_STAGES. `delta_valid` rises in the same cycle.
- **Consumer:** `delta_ready` may be held high permanently. It is then one transfer per cycle in which `inc != 0`.
- **Transfer plus increment:** when `xfer` coincides with `inc != 0`, the register becomes `inc` and `delta_valid` stays high.
- **Mid-operation reset:** state clears immediately and asynchronously. The first post-reset sample is compared against 0.

## Test plan
- **Reset:** assert `reset`, drive `gray_in`=0110. `bin_out`=0, `delta`=0, `delta_valid`=0, `err`=0 and `ovf`=0 throughout reset.
- **Single step:** `delta_ready`=1, `gray_in` 0000 -> 0001. Exactly SYNC_STAGES+1 edges later, `bin_out`=1 and `delta`=1 with `delta_valid`=1 for one cycle, then `delta_valid`=0.
- **Wrap and backpressure:** `WIDTH`=4, `delta_ready`=0.
  - Step the source through Gray codes for 13, 14, 15, 0, 1.
  - Expect `delta`=5 and `bin_out`=1.
  - Raise `delta_ready`: one transfer of 5, then `delta_valid`=0.
- **Transfer with increment:** with `delta`=3, assert `delta_ready` on the same edge that sees `inc`=1. After that edge, `delta`=1 and `delta_valid`=1.
- **Coding error:** `gray_in` jumps 0000 -> 0011.
  - `err` rises SYNC_STAGES+1 edges later and stays high.
  - `clr_err` pulse clears it.
  - A repeated violation on the `clr_err` edge leaves `err`=1.
- **Saturation:** `WIDTH`=4, `delta_ready`=0, 20 single steps. Expect `delta`=15, `ovf`=1, `bin_out`=4 (20 mod 16).
